// File: rtl/div_if.sv
// Handshake and operand/result bundle between a requester and the sequential divider.
interface div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sign_flag;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             div_zero;

  modport master (
    output start, sign_flag, A, B,
    input  busy, done, HI, LO, div_zero
  );

  modport slave (
    input  start, sign_flag, A, B,
    output busy, done, HI, LO, div_zero
  );
endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring divider, one quotient bit per clock; remainder on HI, quotient on LO.
// Signed operands are divided as magnitudes and the signs are restored on the final step.
module div_seq #(
  parameter int WIDTH = 32
) (
  input logic   clk,
  input logic   rst,
  div_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q, dvd_q, dvs_q;
  logic               q_neg_q, r_neg_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               dz_q;

  logic               accept, busy_c, done_c, last;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic               a_neg, b_neg, b_zero;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic               ge;
  logic [WIDTH-1:0]   rem_nxt, dvd_nxt;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  assign a_s    = bus.A;
  assign b_s    = bus.B;
  assign a_neg  = bus.sign_flag && (a_s < 0);
  assign b_neg  = bus.sign_flag && (b_s < 0);
  assign b_zero = (bus.B == '0);

  always_comb begin
    state_d = state_q;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = b_zero ? DONE : ITER;
        end
      end
      ITER: begin
        busy_c = 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
        // A start here chains straight into the next operation.
        if (bus.start) begin
          accept  = 1'b1;
          state_d = b_zero ? DONE : ITER;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign last = (state_q == ITER) && (cnt_q == CNT_W'(1));

  // Iteration step: shift one dividend bit into the remainder, restore if it went negative.
  always_comb begin
    rem_sh   = {rem_q, dvd_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, dvs_q};
    ge       = (rem_sh >= {1'b0, dvs_q});
    rem_nxt  = ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    dvd_nxt  = {dvd_q[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rem_q   <= '0;
      dvd_q   <= cond_neg(bus.A, a_neg);
      dvs_q   <= cond_neg(bus.B, b_neg);
      q_neg_q <= a_neg ^ b_neg;
      r_neg_q <= a_neg;
    end else if (state_q == ITER) begin
      rem_q <= rem_nxt;
      dvd_q <= dvd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && b_zero) begin
        cnt_q <= '0;
        hi_q  <= bus.A;
        lo_q  <= '1;
        dz_q  <= 1'b1;
      end else if (accept) begin
        cnt_q <= CNT_W'(WIDTH);
      end else if (state_q == ITER) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (last) begin
          hi_q <= cond_neg(rem_nxt, r_neg_q);
          lo_q <= cond_neg(dvd_nxt, q_neg_q);
          dz_q <= 1'b0;
        end
      end
    end
  end

  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;
  assign bus.div_zero = dz_q;
endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle 32-bit integer divider; the inverse companion to the combinational MUL unit.
- Serves DIV/DIVU in the datapath and reports results in the same HI/LO form as MUL.
- HI holds the remainder; LO holds the quotient.
- Uses a radix-2 restoring algorithm, one quotient bit per clock, with a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand and result width. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request pulse; operands sampled on the accepting edge.
- sign_flag  input  1  1 = signed divide (DIV), 0 = unsigned (DIVU); sampled with start.
- A  input  WIDTH  dividend.
- B  input  WIDTH  divisor.
- busy  output  1  high while an operation is in progress (ITER state).
- done  output  1  single-cycle pulse; HI/LO/div_zero are valid in that cycle.
- HI  output  WIDTH  remainder; held until the next accepted start.
- LO  output  WIDTH  quotient; held until the next accepted start.
- div_zero  output  1  set with done when B == 0; held like HI/LO.

Behaviour:
- Reset:
  - State goes to IDLE.
  - busy=0, done=0, HI=0, LO=0, div_zero=0, iteration counter=0.
  - Reset mid-operation aborts the operation; no done pulse is issued.
- States: IDLE, ITER, DONE.
- IDLE:
  - start=1 with B!=0: latch |A| and |B| (magnitude only when sign_flag=1), latch the result signs, clear the partial remainder, load counter=WIDTH, go to ITER.
  - start=1 with B==0: go to DONE with HI=A, LO={WIDTH{1}}, div_zero=1.
- ITER:
  - Each cycle, shift {rem, dividend} left by 1.
  - If rem >= divisor: subtract the divisor and shift in quotient bit 1; otherwise shift in 0.
  - Decrement the counter; when it reaches 0, go to DONE.
  - busy=1 throughout ITER.
  - start is ignored in ITER; latched operands are unaffected.
- DONE:
  - done=1 for exactly one cycle.
  - HI/LO are loaded on the edge entering DONE.
  - Signed fixup: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - Next state is IDLE.
  - start asserted in the DONE cycle is accepted exactly as in IDLE (back-to-back operation).
- Latency:
  - start seen at edge N (B!=0): busy high from N+1 to N+WIDTH; done high in cycle N+WIDTH+1.
  - B==0: done in cycle N+1.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0, div_zero=0. No trap.
- Outputs:
  - HI/LO/div_zero change only on the edge entering DONE, or on reset.
  - div_zero is cleared when a non-zero-divisor operation reaches DONE.
  - Operand inputs may change freely after the accepting edge.

Test Plan:
- Unsigned 15/7: sign_flag=0, A=0xF, B=0x7, start 1 cycle -> busy 32 cycles, done at cycle 33, LO=0x2, HI=0x1, div_zero=0.
- Signed vs unsigned, same bits, A=0xFFFFFFF1, B=0x7:
  - sign_flag=1 -> LO=0xFFFFFFFE, HI=0xFFFFFFFF.
  - sign_flag=0 -> LO=0x24924922, HI=0x3.
- Divide by zero: A=0x1234, B=0 -> done 1 cycle after start, HI=0x1234, LO=0xFFFFFFFF, div_zero=1. A following 8/2 operation -> LO=4, HI=0, div_zero=0.
- Signed overflow: sign_flag=1, A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0x0.
- start during busy: second start with different operands at cycle 5 -> ignored, first result unchanged, exactly one done. start in the DONE cycle -> new operation begins, next done 33 cycles later.
- Reset mid-operation: rst at cycle 10 of ITER -> next cycle busy=0, HI=LO=0, no done pulse. A new start afterwards completes normally.
